serie_paralelo_sync: RTL

Single-lane deserializer with comma alignment. It consumes the registered serial bit stream from the input flop stage on `clk_8f` and locates the 8'hBC comma byte boundary. After `BC_LOCK` consecutive aligned commas it declares lock and emits parallel bytes with a one-cycle valid strobe every 8 clocks. Two instances sit downstream of the input flops, one per lane, and feed the lane-merge/FIFO stage.

---
 rtl/phy_pkg.sv | 26 ++
 rtl/serie_paralelo_sync.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/phy_pkg.sv
// -----------------------------------------------------------------------------
// phy_pkg
//   Constants and types shared by the serial-to-parallel lanes of the PHY.
//   Both lanes import this package, so the comma byte and byte width stay
//   identical across lanes.
//
//   sp_state_t    : deserializer FSM states
//   COMMA_BC      : alignment / idle byte
//   BITS_PER_BYTE : serial bits per assembled byte
// -----------------------------------------------------------------------------
package phy_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } sp_state_t;

  localparam logic [7:0] COMMA_BC      = 8'hBC;
  localparam int         BITS_PER_BYTE = 8;

  // Last bit position within a byte; a boundary is reached when the bit
  // counter sits here while the next bit is being shifted in.
  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

endpackage

// File: rtl/serie_paralelo_sync.sv
// -----------------------------------------------------------------------------
// serie_paralelo_sync
//   Single-lane deserializer with comma alignment. Hunts bit by bit for the
//   comma byte, confirms alignment with BC_LOCK consecutive commas on byte
//   boundaries, then emits one parallel byte every 8 clocks.
//
// Parameters
//   BC_LOCK : consecutive aligned commas needed to lock (2..15)
//   COMMA   : alignment / idle byte
//
// Ports
//   clk_8f     in   bit clock, one serial bit per rising edge
//   reset      in   synchronous, active-high
//   data_in    in   serial bit, MSB of each byte first
//   data_out   out  [7:0] assembled byte, held between strobes
//   valid_out  out  one-cycle strobe for a new byte on data_out
//   active_out out  lane locked (sticky until reset)
//
// Build option
//   SP_COMMA_FILTER_EN : when defined, comma bytes received while locked
//                        update data_out but do not raise valid_out.
// -----------------------------------------------------------------------------
module serie_paralelo_sync
  import phy_pkg::*;
#(
  parameter int         BC_LOCK = 4,
  parameter logic [7:0] COMMA   = COMMA_BC
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active_out
);

`ifdef SP_COMMA_FILTER_EN
  localparam bit FILTER_COMMA = 1'b1;
`else
  localparam bit FILTER_COMMA = 1'b0;
`endif

  localparam logic [4:0] LOCK_CNT = 5'(BC_LOCK);

  sp_state_t  state_q,   state_d;
  logic [7:0] shift_q,   shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q,  bc_cnt_d;
  logic [7:0] data_q,    data_d;
  logic       valid_q,   valid_d;
  logic       active_q,  active_d;

  logic [7:0] word_next;
  logic       is_comma;
  logic       boundary;
  logic [4:0] bc_cnt_inc;

  // The window already includes the bit arriving this cycle, so every
  // decision below is made on the same edge that completes the byte.
  assign word_next  = {shift_q[6:0], data_in};
  assign is_comma   = (word_next == COMMA);
  assign boundary   = (bit_cnt_q == LAST_BIT);
  assign bc_cnt_inc = {1'b0, bc_cnt_q} + 5'd1;

  always_comb begin
    state_d   = state_q;
    shift_d   = word_next;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    active_d  = active_q;

    unique case (state_q)
      SEARCH: begin
        // Bit-level hunt: any bit position may complete a comma.
        if (is_comma) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = ALIGN;
        end
      end

      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma && (bc_cnt_inc == LOCK_CNT)) begin
            // Locking comma is consumed here; it never reaches data_out.
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else if (is_comma) begin
            if (bc_cnt_q != 4'hF) bc_cnt_d = bc_cnt_inc[3:0];
          end else begin
            // Rejected byte is not rescanned; the hunt restarts with the
            // next incoming bit using the shifted window as-is.
            state_d   = SEARCH;
            bc_cnt_d  = 4'd0;
            bit_cnt_d = 3'd0;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d  = word_next;
          valid_d = !(FILTER_COMMA && is_comma);
        end
      end

      default: begin
        state_d   = SEARCH;
        bit_cnt_d = 3'd0;
        bc_cnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q   <= SEARCH;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign active_out = active_q;

endmodule
